// File: rtl/f3m_pkg.sv
// Shared GF(3)/GF(3^M) definitions: coefficient encoding, digit-serial helpers,
// the default reduction polynomial for M=97 and the per-coefficient GF(3) add/mul cells.
package f3m_pkg;

  localparam int unsigned F3_W = 2;

  localparam logic [F3_W-1:0] F3_ZERO = 2'b00;
  localparam logic [F3_W-1:0] F3_ONE  = 2'b01;
  localparam logic [F3_W-1:0] F3_TWO  = 2'b10;

  // f(x) = x^97 + x^12 + 2: f0 = 2, f12 = 1, all other low coefficients zero
  localparam int unsigned F3M_M_DEFAULT = 97;
  localparam logic [F3_W*F3M_M_DEFAULT-1:0] F3M_POLY_DEFAULT =
    ((F3_W*F3M_M_DEFAULT)'(F3_ONE) << (F3_W*12)) | (F3_W*F3M_M_DEFAULT)'(F3_TWO);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } f3m_state_e;

  // Number of digit groups (compute cycles) for an M-coefficient operand, D digits per group
  function automatic int unsigned f3m_num_groups(input int unsigned m, input int unsigned d);
    return (m + d - 1) / d;
  endfunction

  // The unused code 2'b11 reads as zero
  function automatic logic [F3_W-1:0] f3_norm(input logic [F3_W-1:0] x);
    return (x == 2'b11) ? F3_ZERO : x;
  endfunction

  function automatic logic [F3_W-1:0] f3_add(input logic [F3_W-1:0] x, input logic [F3_W-1:0] y);
    logic [2:0] s;
    s = {1'b0, f3_norm(x)} + {1'b0, f3_norm(y)};
    if (s >= 3'd3) s = s - 3'd3;
    return s[F3_W-1:0];
  endfunction

  function automatic logic [F3_W-1:0] f3_neg(input logic [F3_W-1:0] x);
    case (f3_norm(x))
      F3_ONE:  return F3_TWO;
      F3_TWO:  return F3_ONE;
      default: return F3_ZERO;
    endcase
  endfunction

  function automatic logic [F3_W-1:0] f3_mul(input logic [F3_W-1:0] x, input logic [F3_W-1:0] y);
    case (f3_norm(x))
      F3_ONE:  return f3_norm(y);
      F3_TWO:  return f3_neg(y);
      default: return F3_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/f3m_mac_step.sv
// One MSB-first digit-serial step over GF(3^M): acc_o_c = acc_i*x mod f + b_digit_i*a_i.
// Ports:
//   acc_i      running accumulator (M coefficients, 2 bits each)
//   a_i        multiplicand A
//   b_digit_i  current GF(3) digit of B
//   acc_o_c    updated accumulator (combinational)
module f3m_mac_step
  import f3m_pkg::*;
#(
  parameter int unsigned        M    = F3M_M_DEFAULT,
  parameter logic [F3_W*M-1:0]  POLY = (F3_W*M)'(F3M_POLY_DEFAULT)
) (
  input  logic [F3_W*M-1:0] acc_i,
  input  logic [F3_W*M-1:0] a_i,
  input  logic [F3_W-1:0]   b_digit_i,
  output logic [F3_W*M-1:0] acc_o_c
);

  // Coefficient shifted out of x^(M-1); x^M = -f_low, so it folds back as -t*f_low
  logic [F3_W-1:0] fold;
  assign fold = f3_neg(acc_i[F3_W*M-1 -: F3_W]);

  for (genvar i = 0; i < int'(M); i++) begin : g_coef
    logic [F3_W-1:0] shifted;
    if (i == 0) begin : g_low
      assign shifted = F3_ZERO;
    end else begin : g_up
      assign shifted = acc_i[F3_W*(i-1) +: F3_W];
    end
    assign acc_o_c[F3_W*i +: F3_W] =
      f3_add(f3_add(shifted, f3_mul(fold, POLY[F3_W*i +: F3_W])),
             f3_mul(b_digit_i, a_i[F3_W*i +: F3_W]));
  end

endmodule

// File: rtl/f3m_mult_serial.sv
// Digit-serial GF(3^M) multiplier: c = a*b mod f, D digits of b per clock, MSB first.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   start       accepted in IDLE (including the done cycle); samples a and b
//   a, b        operands, coefficient i at [2i+1:2i]
//   c           last completed product, held until the next completion
//   busy        high for the ceil(M/D) compute cycles
//   done        one-cycle pulse when c is updated
module f3m_mult_serial
  import f3m_pkg::*;
#(
  parameter int unsigned        M    = F3M_M_DEFAULT,
  parameter int unsigned        D    = 1,
  parameter logic [F3_W*M-1:0]  POLY = (F3_W*M)'(F3M_POLY_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [F3_W*M-1:0] a,
  input  logic [F3_W*M-1:0] b,
  output logic [F3_W*M-1:0] c,
  output logic              busy,
  output logic              done
);

  localparam int unsigned AW    = F3_W * M;
  localparam int unsigned N     = f3m_num_groups(M, D);
  localparam int unsigned BW    = F3_W * N * D;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  f3m_state_e       state_q, state_d;
  logic [AW-1:0]    a_q, a_d;
  logic [BW-1:0]    b_q, b_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    c_q, c_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Chain of D steps; b_q keeps the current digit group at its top, high digit first
  logic [AW-1:0] acc_chain [D+1];
  assign acc_chain[0] = acc_q;

  for (genvar s = 0; s < int'(D); s++) begin : g_step
    f3m_mac_step #(
      .M    (M),
      .POLY (POLY)
    ) u_step (
      .acc_i     (acc_chain[s]),
      .a_i       (a_q),
      .b_digit_i (b_q[BW-1-F3_W*s -: F3_W]),
      .acc_o_c   (acc_chain[s+1])
    );
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      c_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = BW'(b);  // zero-padded above digit M-1
          acc_d   = '0;
          cnt_d   = CNT_W'(N - 1);
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d = acc_chain[D];
        b_d   = b_q << (F3_W * D);
        if (cnt_q == CNT_W'(0)) begin
          c_d     = acc_chain[D];
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d  = cnt_q - CNT_W'(1);
          busy_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign c    = c_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_f3m_mult_serial.sv
module tb_f3m_mult_serial;

  localparam logic [9:0] POLY5 = 10'b00_00_00_10_01;  // f = x^5 + 2x + 1

  localparam logic [9:0] P_ONE  = 10'b00_00_00_00_01;
  localparam logic [9:0] P_X    = 10'b00_00_00_01_00;
  localparam logic [9:0] P_X2   = 10'b00_00_01_00_00;
  localparam logic [9:0] P_X4   = 10'b01_00_00_00_00;
  localparam logic [9:0] P_XP2  = 10'b00_00_00_01_10;  // x + 2
  localparam logic [9:0] P_SQ   = 10'b01_10_00_00_00;  // x^4 + 2x^3
  localparam logic [9:0] P_B3   = 10'b10_00_01_00_01;  // 2x^4 + x^2 + 1
  localparam logic [9:0] P_X3X  = 10'b00_01_00_01_00;  // x^3 + x
  localparam logic [9:0] P_B2B  = 10'b00_01_00_01_10;  // x^3 + x + 2
  localparam logic [9:0] P_X32  = 10'b00_01_00_00_10;  // x^3 + 2

  logic clk;
  logic reset;

  logic       start51, start52;
  logic [9:0] a5, b5;
  logic [9:0] c51, c52;
  logic       busy51, busy52, done51, done52;

  logic         start97;
  logic [193:0] a97, b97;
  logic [193:0] c97_1, c97_4, c97_97;
  logic         busy97_1, busy97_4, busy97_97;
  logic         done97_1, done97_4, done97_97;

  int checks;
  int failures;

  f3m_mult_serial #(.M(5), .D(1), .POLY(POLY5)) u_m5_d1 (
    .clk(clk), .reset(reset), .start(start51), .a(a5), .b(b5),
    .c(c51), .busy(busy51), .done(done51)
  );

  f3m_mult_serial #(.M(5), .D(2), .POLY(POLY5)) u_m5_d2 (
    .clk(clk), .reset(reset), .start(start52), .a(a5), .b(b5),
    .c(c52), .busy(busy52), .done(done52)
  );

  f3m_mult_serial #(.M(97), .D(1)) u_m97_d1 (
    .clk(clk), .reset(reset), .start(start97), .a(a97), .b(b97),
    .c(c97_1), .busy(busy97_1), .done(done97_1)
  );

  f3m_mult_serial #(.M(97), .D(4)) u_m97_d4 (
    .clk(clk), .reset(reset), .start(start97), .a(a97), .b(b97),
    .c(c97_4), .busy(busy97_4), .done(done97_4)
  );

  f3m_mult_serial #(.M(97), .D(97)) u_m97_d97 (
    .clk(clk), .reset(reset), .start(start97), .a(a97), .b(b97),
    .c(c97_97), .busy(busy97_97), .done(done97_97)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int dec3(input logic [1:0] v);
    return (v == 2'b11) ? 0 : int'(v);
  endfunction

  // Schoolbook product, then reduce top-down with x^97 = 2x^12 + 1
  function automatic logic [193:0] ref97(input logic [193:0] x, input logic [193:0] y);
    int p [193];
    logic [193:0] r;
    for (int k = 0; k < 193; k++) p[k] = 0;
    for (int i = 0; i < 97; i++)
      for (int j = 0; j < 97; j++)
        p[i+j] += dec3(x[2*i +: 2]) * dec3(y[2*j +: 2]);
    for (int k = 192; k >= 97; k--) begin
      int t;
      t = p[k] % 3;
      p[k-85] += 2 * t;
      p[k-97] += t;
    end
    r = '0;
    for (int i = 0; i < 97; i++) r[2*i +: 2] = 2'(p[i] % 3);
    return r;
  endfunction

  function automatic logic [9:0] cur_c(input int sel);
    return (sel == 0) ? c51 : c52;
  endfunction

  function automatic logic cur_done(input int sel);
    return (sel == 0) ? done51 : done52;
  endfunction

  function automatic logic cur_busy(input int sel);
    return (sel == 0) ? busy51 : busy52;
  endfunction

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) start51 = v;
    else          start52 = v;
  endtask

  // Start a multiply on an M=5 instance and follow it to its done pulse
  task automatic run5(input int sel, input logic [9:0] av, input logic [9:0] bv,
                      input logic [9:0] ce, input int lat_exp, input bit spur,
                      input string tag);
    int lat, nbusy, hold_bad;
    logic [9:0] c_prev;
    c_prev = cur_c(sel);
    a5 = av;
    b5 = bv;
    set_start(sel, 1'b1);
    step();
    set_start(sel, 1'b0);
    lat = 0; nbusy = 0; hold_bad = 0;
    for (int k = 1; k <= 40; k++) begin
      if (cur_done(sel)) begin
        lat = k;
        break;
      end
      if (cur_busy(sel)) nbusy++;
      if (cur_c(sel) !== c_prev) hold_bad++;
      if (spur && (k == 2 || k == 4)) begin
        a5 = P_X4;
        b5 = P_X4;
        set_start(sel, 1'b1);
      end else begin
        set_start(sel, 1'b0);
      end
      step();
    end
    set_start(sel, 1'b0);
    chk({tag, "_lat"}, 256'(lat), 256'(lat_exp));
    chk({tag, "_busy"}, 256'(nbusy), 256'(lat_exp - 1));
    chk({tag, "_hold"}, 256'(hold_bad), 256'(0));
    chk({tag, "_c"}, 256'(cur_c(sel)), 256'(ce));
  endtask

  task automatic quiet5(input int cycles, input string tag);
    int nd;
    nd = 0;
    for (int k = 0; k < cycles; k++) begin
      step();
      if (done51) nd++;
    end
    chk(tag, 256'(nd), 256'(0));
  endtask

  initial begin
    logic [223:0] ta, tb;
    logic [193:0] exp97;
    int lat1, lat4, lat97;

    checks = 0;
    failures = 0;
    reset = 1'b1;
    start51 = 1'b0; start52 = 1'b0; start97 = 1'b0;
    a5 = '0; b5 = '0; a97 = '0; b97 = '0;
    repeat (3) step();
    reset = 1'b0;
    step();

    chk("rst_c",    256'(c51),    256'(0));
    chk("rst_busy", 256'(busy51), 256'(0));
    chk("rst_done", 256'(done51), 256'(0));
    chk("rst_c97",  256'(c97_4),  256'(0));

    // Basic reduction and squaring, D=1 and D=2 (zero-padded B)
    run5(0, P_X4, P_X, P_XP2, 6, 1'b0, "t1_basic");
    run5(0, P_X4, P_X4, P_SQ, 6, 1'b0, "t2_sq_d1");
    run5(1, P_X4, P_X4, P_SQ, 4, 1'b0, "t2_sq_d2");

    // Identity, zero, and the 2'b11 digit read as zero
    step();
    run5(0, P_ONE, P_B3, P_B3, 6, 1'b0, "t3_ident");
    run5(0, 10'd0, 10'b01_10_01_10_01, 10'd0, 6, 1'b0, "t3_zero");
    run5(0, 10'b00_00_00_11_01, P_X32, P_X32, 6, 1'b0, "t3_d11");

    // Back-to-back start in the done cycle, then starts during busy
    step();
    run5(0, P_X4, P_X, P_XP2, 6, 1'b0, "t4_first");
    run5(0, P_X2, P_X3X, P_B2B, 6, 1'b0, "t4_b2b");
    step();
    run5(0, P_X, P_X, P_X2, 6, 1'b1, "t4_spur");
    quiet5(8, "t4_no_extra_done");

    // Reset on the second RUN cycle aborts without a done
    a5 = P_X4; b5 = P_X4; start51 = 1'b1;
    step();
    start51 = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t5_busy", 256'(busy51), 256'(0));
    chk("t5_done", 256'(done51), 256'(0));
    chk("t5_c",    256'(c51),    256'(0));
    quiet5(8, "t5_no_done");
    run5(0, P_X4, P_X, P_XP2, 6, 1'b0, "t5_after");

    // Random M=97 products against the reference, three digit widths
    for (int v = 0; v < 5; v++) begin
      for (int w = 0; w < 7; w++) begin
        ta[w*32 +: 32] = $urandom();
        tb[w*32 +: 32] = $urandom();
      end
      a97 = ta[193:0];
      b97 = tb[193:0];
      exp97 = ref97(a97, b97);
      start97 = 1'b1;
      step();
      start97 = 1'b0;
      lat1 = 0; lat4 = 0; lat97 = 0;
      for (int k = 1; k <= 110; k++) begin
        if (done97_1 && lat1 == 0) begin
          lat1 = k;
          chk($sformatf("r%0d_c_d1", v), 256'(c97_1), 256'(exp97));
        end
        if (done97_4 && lat4 == 0) begin
          lat4 = k;
          chk($sformatf("r%0d_c_d4", v), 256'(c97_4), 256'(exp97));
        end
        if (done97_97 && lat97 == 0) begin
          lat97 = k;
          chk($sformatf("r%0d_c_d97", v), 256'(c97_97), 256'(exp97));
        end
        if (lat1 != 0 && lat4 != 0 && lat97 != 0) break;
        step();
      end
      chk($sformatf("r%0d_lat_d1", v),  256'(lat1),  256'(98));
      chk($sformatf("r%0d_lat_d4", v),  256'(lat4),  256'(26));
      chk($sformatf("r%0d_lat_d97", v), 256'(lat97), 256'(2));
      chk($sformatf("r%0d_idle", v), 256'({busy97_1, busy97_4, busy97_97}), 256'(0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
